// File: rtl/butterfly_r4_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_r4_pipe_if
//  Description : Handshake and data bundle for the radix-4 butterfly.
//                master = producer/consumer side (controller, bench)
//                slave  = butterfly side
//  Signals     : in_valid/in_ready, calc_in {D,C,B,A}, tw_in {W3,W2,W1},
//                tw_bypass, inverse, scale, out_valid/out_ready,
//                calc_out {X3,X2,X1,X0}, ovf
//  Revision    : 1.0  initial release
// ============================================================================
interface butterfly_r4_pipe_if #(
    parameter int DW = 17,
    parameter int TW = 9,
    parameter int SW = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [8*DW-1:0]   calc_in;
    logic [6*TW-1:0]   tw_in;
    logic              tw_bypass;
    logic              inverse;
    logic [SW-1:0]     scale;
    logic              out_valid;
    logic              out_ready;
    logic [8*DW-1:0]   calc_out;
    logic              ovf;

    modport master (
        output in_valid, calc_in, tw_in, tw_bypass, inverse, scale, out_ready,
        input  in_ready, out_valid, calc_out, ovf
    );

    modport slave (
        input  in_valid, calc_in, tw_in, tw_bypass, inverse, scale, out_ready,
        output in_ready, out_valid, calc_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/butterfly_r4_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_r4_pipe
//  Description : Three-stage pipelined radix-4 butterfly. Twiddles W1..W3 are
//                applied to B, C, D (conjugated in inverse mode, skipped in
//                bypass mode), then the 4-point DFT is formed, scaled by a
//                rounded arithmetic right shift and saturated to DW bits.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - butterfly_r4_pipe_if.slave (valid/ready in and out)
//  Revision    : 1.0  initial release
// ============================================================================
module butterfly_r4_pipe #(
    parameter int DW = 17,
    parameter int TW = 9,
    parameter int SW = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    butterfly_r4_pipe_if.slave    bus
);
    // Working width: wide enough for a full twiddle product sum and for the
    // butterfly sums plus the scaling round constant.
    localparam int                    c_xw     = DW + TW + 1;
    localparam logic signed [c_xw-1:0] c_max    = c_xw'((2 ** (DW - 1)) - 1);
    localparam logic signed [c_xw-1:0] c_min    = c_xw'(-(2 ** (DW - 1)));
    localparam logic signed [c_xw-1:0] c_tw_rnd = c_xw'(2 ** (TW - 3));

    function automatic logic signed [c_xw-1:0] sx(input logic [DW-1:0] v);
        return $signed({{(c_xw - DW){v[DW-1]}}, v});
    endfunction

    function automatic logic signed [c_xw-1:0] sxw(input logic [TW-1:0] v);
        return $signed({{(c_xw - TW){v[TW-1]}}, v});
    endfunction

    // Returns {clamped, value}.
    function automatic logic [DW:0] sat_dw(input logic signed [c_xw-1:0] v);
        if (v > c_max)      return {1'b1, c_max[DW-1:0]};
        else if (v < c_min) return {1'b1, c_min[DW-1:0]};
        else                return {1'b0, v[DW-1:0]};
    endfunction

    // One component of a complex product: x0*w0 +/- x1*w1, rounded half up
    // back to data scale.
    function automatic logic [DW:0] tw_term(input logic [DW-1:0] x0, input logic [TW-1:0] w0,
                                            input logic [DW-1:0] x1, input logic [TW-1:0] w1,
                                            input logic sub);
        logic signed [c_xw-1:0] p0;
        logic signed [c_xw-1:0] p1;
        logic signed [c_xw-1:0] acc;
        p0  = sx(x0) * sxw(w0);
        p1  = sx(x1) * sxw(w1);
        acc = sub ? (p0 - p1) : (p0 + p1);
        acc = (acc + c_tw_rnd) >>> (TW - 2);
        return sat_dw(acc);
    endfunction

    function automatic logic [DW:0] scale_sat(input logic signed [c_xw-1:0] v,
                                              input logic [SW-1:0] sc);
        logic signed [c_xw-1:0] rnd;
        rnd = '0;
        if (sc != '0) rnd = c_xw'(1) <<< (sc - 1'b1);
        return sat_dw((v + rnd) >>> sc);
    endfunction

    // Global stall: every stage advances together or not at all.
    logic w_en;
    logic r_s3_valid;
    assign w_en         = bus.out_ready | ~r_s3_valid;
    assign bus.in_ready = w_en;

    // ---------------- S1: input capture ----------------
    logic              r_s1_valid;
    logic [8*DW-1:0]   r_s1_data;
    logic [6*TW-1:0]   r_s1_tw;
    logic              r_s1_byp;
    logic              r_s1_inv;
    logic [SW-1:0]     r_s1_scale;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tw    <= '0;
            r_s1_byp   <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_scale <= '0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_data  <= bus.calc_in;
            r_s1_tw    <= bus.tw_in;
            r_s1_byp   <= bus.tw_bypass;
            r_s1_inv   <= bus.inverse;
            r_s1_scale <= bus.scale;
        end
    end

    // ---------------- twiddle multiply ----------------
    logic [8*DW-1:0] w_s2_data;
    logic [3:1]      w_tw_ovf;

    assign w_s2_data[2*DW-1:0] = r_s1_data[2*DW-1:0];

    for (genvar k = 1; k <= 3; k++) begin : g_tw
        logic [DW-1:0] w_xr, w_xi;
        logic [TW-1:0] w_wr, w_wi;
        logic [DW:0]   w_pr, w_pi;
        assign w_xr = r_s1_data[(2*k+2)*DW-1 -: DW];
        assign w_xi = r_s1_data[(2*k+1)*DW-1 -: DW];
        assign w_wr = r_s1_tw[(2*k)*TW-1 -: TW];
        assign w_wi = r_s1_tw[(2*k-1)*TW-1 -: TW];
        // Forward: (xr*wr - xi*wi, xi*wr + xr*wi); inverse flips the wi sign.
        assign w_pr = tw_term(w_xr, w_wr, w_xi, w_wi, ~r_s1_inv);
        assign w_pi = tw_term(w_xi, w_wr, w_xr, w_wi, r_s1_inv);
        assign w_s2_data[(2*k+2)*DW-1 -: DW] = r_s1_byp ? w_xr : w_pr[DW-1:0];
        assign w_s2_data[(2*k+1)*DW-1 -: DW] = r_s1_byp ? w_xi : w_pi[DW-1:0];
        assign w_tw_ovf[k] = ~r_s1_byp & (w_pr[DW] | w_pi[DW]);
    end

    // ---------------- S2: twiddled operands ----------------
    logic              r_s2_valid;
    logic [8*DW-1:0]   r_s2_data;
    logic              r_s2_inv;
    logic [SW-1:0]     r_s2_scale;
    logic              r_s2_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_inv   <= 1'b0;
            r_s2_scale <= '0;
            r_s2_ovf   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_s2_data;
            r_s2_inv   <= r_s1_inv;
            r_s2_scale <= r_s1_scale;
            r_s2_ovf   <= |w_tw_ovf;
        end
    end

    // ---------------- butterfly ----------------
    logic signed [c_xw-1:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
    logic signed [c_xw-1:0] w_t1r, w_t1i, w_t3r, w_t3i;
    logic signed [c_xw-1:0] w_xr [4];
    logic signed [c_xw-1:0] w_xi [4];

    assign w_ar = sx(r_s2_data[2*DW-1 -: DW]);
    assign w_ai = sx(r_s2_data[1*DW-1 -: DW]);
    assign w_br = sx(r_s2_data[4*DW-1 -: DW]);
    assign w_bi = sx(r_s2_data[3*DW-1 -: DW]);
    assign w_cr = sx(r_s2_data[6*DW-1 -: DW]);
    assign w_ci = sx(r_s2_data[5*DW-1 -: DW]);
    assign w_dr = sx(r_s2_data[8*DW-1 -: DW]);
    assign w_di = sx(r_s2_data[7*DW-1 -: DW]);

    // t1 = A - jB - C + jD, t3 = A + jB - C - jD; inverse swaps them.
    assign w_t1r = w_ar + w_bi - w_cr - w_di;
    assign w_t1i = w_ai - w_br - w_ci + w_dr;
    assign w_t3r = w_ar - w_bi - w_cr + w_di;
    assign w_t3i = w_ai + w_br - w_ci - w_dr;

    assign w_xr[0] = w_ar + w_br + w_cr + w_dr;
    assign w_xi[0] = w_ai + w_bi + w_ci + w_di;
    assign w_xr[1] = r_s2_inv ? w_t3r : w_t1r;
    assign w_xi[1] = r_s2_inv ? w_t3i : w_t1i;
    assign w_xr[2] = w_ar - w_br + w_cr - w_dr;
    assign w_xi[2] = w_ai - w_bi + w_ci - w_di;
    assign w_xr[3] = r_s2_inv ? w_t1r : w_t3r;
    assign w_xi[3] = r_s2_inv ? w_t1i : w_t3i;

    logic [8*DW-1:0] w_s3_data;
    logic [7:0]      w_clamp;

    for (genvar k = 0; k < 4; k++) begin : g_out
        logic [DW:0] w_sr, w_si;
        assign w_sr = scale_sat(w_xr[k], r_s2_scale);
        assign w_si = scale_sat(w_xi[k], r_s2_scale);
        assign w_s3_data[(2*k+2)*DW-1 -: DW] = w_sr[DW-1:0];
        assign w_s3_data[(2*k+1)*DW-1 -: DW] = w_si[DW-1:0];
        assign w_clamp[2*k]   = w_sr[DW];
        assign w_clamp[2*k+1] = w_si[DW];
    end

    // ---------------- S3: output register ----------------
    logic [8*DW-1:0] r_s3_data;
    logic            r_s3_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_ovf   <= 1'b0;
        end else if (w_en) begin
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_s3_data;
            r_s3_ovf   <= (|w_clamp) | r_s2_ovf;
        end
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.calc_out  = r_s3_data;
    assign bus.ovf       = r_s3_ovf;
endmodule
`default_nettype wire

// File: tb/tb_butterfly_r4_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_butterfly_r4_pipe
//  Description : Directed self-checking bench for butterfly_r4_pipe. Expected
//                outputs are queued when a beat is accepted and compared in
//                order when the butterfly presents a beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_butterfly_r4_pipe;
    localparam int DW = 17;
    localparam int TW = 9;
    localparam int SW = 2;
    localparam int BW = 8 * DW;

    typedef struct {
        logic [BW-1:0] data;
        logic          ovf;
        int            stamp;
    } exp_t;

    logic clk;
    logic reset;

    butterfly_r4_pipe_if #(.DW(DW), .TW(TW), .SW(SW)) bus ();

    butterfly_r4_pipe #(.DW(DW), .TW(TW), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t          exp_q[$];
    exp_t          nxt;
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic          lat_chk = 1'b0;
    logic          exp_rdy = 1'b1;
    logic          hold_chk = 1'b0;
    logic [BW-1:0] held_data;
    logic          held_ovf;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] cp(input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        return {r[DW-1:0], i[DW-1:0]};
    endfunction

    function automatic logic [BW-1:0] pk(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                         input logic [2*DW-1:0] c, input logic [2*DW-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [6*TW-1:0] twv(input int w1r, input int w1i, input int w2r,
                                            input int w2i, input int w3r, input int w3i);
        logic [31:0] v [6];
        v[0] = w1r; v[1] = w1i; v[2] = w2r; v[3] = w2i; v[4] = w3r; v[5] = w3i;
        return {v[4][TW-1:0], v[5][TW-1:0], v[2][TW-1:0], v[3][TW-1:0], v[0][TW-1:0], v[1][TW-1:0]};
    endfunction

    // One clock: evaluate transfers mid low phase, then advance to next negedge.
    task automatic step(output logic acc);
        exp_t e;
        #1;
        chk("in_ready", BW'(bus.in_ready), BW'(exp_rdy));
        acc = bus.in_valid & bus.in_ready;
        if (acc) begin
            e = nxt;
            e.stamp = cyc;
            exp_q.push_back(e);
        end
        if (hold_chk) begin
            chk("hold_data", bus.calc_out, held_data);
            chk("hold_ovf", BW'(bus.ovf), BW'(held_ovf));
        end
        hold_chk  = bus.out_valid & ~bus.out_ready;
        held_data = bus.calc_out;
        held_ovf  = bus.ovf;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", BW'(bus.out_valid), BW'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("calc_out", bus.calc_out, e.data);
                chk("ovf", BW'(bus.ovf), BW'(e.ovf));
                if (lat_chk) chk("latency", BW'(cyc - e.stamp), BW'(3));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [BW-1:0] d, input logic [6*TW-1:0] w, input logic byp,
                        input logic inv, input logic [SW-1:0] sc,
                        input logic [BW-1:0] xd, input logic xo);
        logic acc;
        int   n;
        bus.calc_in   = d;
        bus.tw_in     = w;
        bus.tw_bypass = byp;
        bus.inverse   = inv;
        bus.scale     = sc;
        bus.in_valid  = 1'b1;
        nxt.data = xd;
        nxt.ovf  = xo;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", BW'(acc), BW'(1'b1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step(acc);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", BW'(exp_q.size()), BW'(0));
    endtask

    initial begin
        logic          acc;
        int            sent;
        int            c;
        int            av;
        logic [BW-1:0] z;
        z = '0;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.calc_in   = '0;
        bus.tw_in     = '0;
        bus.tw_bypass = 1'b1;
        bus.inverse   = 1'b0;
        bus.scale     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", BW'(bus.out_valid), BW'(1'b0));
        chk("rst_calc_out", bus.calc_out, z);
        chk("rst_ovf", BW'(bus.ovf), BW'(1'b0));
        reset = 1'b1;
        #1;
        chk("rst_in_ready", BW'(bus.in_ready), BW'(1'b1));
        @(negedge clk);

        // Latency and plain sums
        lat_chk = 1'b1;
        send(pk(cp(100,0), cp(100,0), cp(100,0), cp(100,0)), '0, 1'b1, 1'b0, 2'd0,
             pk(cp(400,0), cp(0,0), cp(0,0), cp(0,0)), 1'b0);
        drain();
        lat_chk = 1'b0;

        // j terms, forward and inverse
        send(pk(cp(0,0), cp(100,0), cp(0,0), cp(0,0)), '0, 1'b1, 1'b0, 2'd0,
             pk(cp(100,0), cp(0,-100), cp(-100,0), cp(0,100)), 1'b0);
        send(pk(cp(0,0), cp(100,0), cp(0,0), cp(0,0)), '0, 1'b1, 1'b1, 2'd0,
             pk(cp(100,0), cp(0,100), cp(-100,0), cp(0,-100)), 1'b0);

        // Twiddle W1 = -j: B' = (0,-100)
        send(pk(cp(0,0), cp(100,0), cp(0,0), cp(0,0)), twv(0,-128,128,0,128,0), 1'b0, 1'b0, 2'd0,
             pk(cp(0,-100), cp(-100,0), cp(0,100), cp(100,0)), 1'b0);
        // Same twiddle in inverse mode: conj(W1) = +j, B' = (0,100)
        send(pk(cp(0,0), cp(100,0), cp(0,0), cp(0,0)), twv(0,-128,128,0,128,0), 1'b0, 1'b1, 2'd0,
             pk(cp(0,100), cp(-100,0), cp(0,-100), cp(100,0)), 1'b0);
        // Half-up rounding: (3,-3)*0.5 = (1.5,-1.5) -> (2,-1)
        send(pk(cp(0,0), cp(3,-3), cp(0,0), cp(0,0)), twv(64,0,128,0,128,0), 1'b0, 1'b0, 2'd0,
             pk(cp(2,-1), cp(-1,-2), cp(-2,1), cp(1,2)), 1'b0);
        // Twiddle-stage clamp: (-65536,-65536)*(-2) -> (65535,65535), ovf from S2 only
        send(pk(cp(0,0), cp(-65536,-65536), cp(0,0), cp(0,0)), twv(-256,0,128,0,128,0), 1'b0, 1'b0, 2'd0,
             pk(cp(65535,65535), cp(65535,-65535), cp(-65535,-65535), cp(-65535,65535)), 1'b1);

        // Saturation and scaling
        send(pk(cp(65535,0), cp(65535,0), cp(65535,0), cp(65535,0)), '0, 1'b1, 1'b0, 2'd0,
             pk(cp(65535,0), cp(0,0), cp(0,0), cp(0,0)), 1'b1);
        send(pk(cp(65535,0), cp(65535,0), cp(65535,0), cp(65535,0)), '0, 1'b1, 1'b0, 2'd2,
             pk(cp(65535,0), cp(0,0), cp(0,0), cp(0,0)), 1'b0);
        // Scale rounding: (3+1)>>>1 = 2, (-3+1)>>>1 = -1
        send(pk(cp(3,-3), cp(0,0), cp(0,0), cp(0,0)), '0, 1'b1, 1'b0, 2'd1,
             pk(cp(2,-1), cp(2,-1), cp(2,-1), cp(2,-1)), 1'b0);
        drain();

        // Backpressure: 10 back-to-back beats, out_ready low in cycles 4..8
        bus.tw_bypass = 1'b1;
        bus.inverse   = 1'b0;
        bus.scale     = '0;
        sent = 0;
        c = 0;
        while ((sent < 10 || exp_q.size() > 0) && c < 80) begin
            bus.out_ready = !(c >= 4 && c <= 8);
            exp_rdy       = !(c >= 4 && c <= 8);
            bus.in_valid  = (sent < 10);
            av = sent * 1234 - 5000;
            bus.calc_in = pk(cp(av, -av), cp(0,0), cp(0,0), cp(0,0));
            nxt.data    = pk(cp(av, -av), cp(av, -av), cp(av, -av), cp(av, -av));
            nxt.ovf     = 1'b0;
            step(acc);
            if (acc) sent++;
            c++;
        end
        chk("bp_sent", BW'(sent), BW'(10));
        chk("bp_drained", BW'(exp_q.size()), BW'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_rdy       = 1'b1;

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            bus.calc_in  = pk(cp(777 + i, 0), cp(0,0), cp(0,0), cp(0,0));
            nxt.data     = pk(cp(777 + i, 0), cp(777 + i, 0), cp(777 + i, 0), cp(777 + i, 0));
            nxt.ovf      = 1'b0;
            bus.in_valid = 1'b1;
            step(acc);
        end
        bus.in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", BW'(bus.out_valid), BW'(1'b0));
        chk("midrst_calc_out", bus.calc_out, z);
        chk("midrst_ovf", BW'(bus.ovf), BW'(1'b0));
        exp_q.delete();
        hold_chk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lat_chk = 1'b1;
        send(pk(cp(-20,30), cp(5,0), cp(0,0), cp(0,0)), '0, 1'b1, 1'b0, 2'd0,
             pk(cp(-15,30), cp(-20,25), cp(-25,30), cp(-20,35)), 1'b0);
        drain();
        lat_chk = 1'b0;
        repeat (8) step(acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/butterfly_r4_pipe.md
Name: butterfly_r4_pipe

Overview:
- Parametrised, pipelined radix-4 butterfly with valid/ready handshake on both sides.
- Applies three externally supplied twiddles (W^P, W^2P, W^3P) to inputs B, C and D, then performs the 4-point DFT.
- Supports forward/inverse mode, a twiddle-bypass mode for the first stage, per-beat right-shift scaling, and saturation with an overflow flag.
- Sits between the serial/parallel reorder buffer and the FFT controller, and is reused for every stage of an N-point radix-4 FFT.

Parameters:
- DW, 17: signed width of each Re/Im data component.
- TW, 9: signed width of each twiddle component, format Q1.(TW-2); 1.0 = 2^(TW-2) = 128.
- SW, 2: width of the scale input; shift range is 0..2^SW-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- calc_in  in  8*DW  {in4(Re,Im), in3, in2, in1} = {D, C, B, A}; Re is the upper half of each pair.
- tw_in  in  6*TW  {W3(Re,Im), W2, W1}; sampled with the beat.
- tw_bypass  in  1  treat W1..W3 as 1.0.
- inverse  in  1  0 = forward, 1 = inverse.
- scale  in  SW  arithmetic right-shift applied to the butterfly sums.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- calc_out  out  8*DW  {X3, X2, X1, X0}, each (Re,Im).
- ovf  out  1  one or more outputs saturated in this beat; qualified by out_valid.

Behaviour:
- Reset (reset=0, async): all stage valids = 0, calc_out = 0, ovf = 0, in_ready = 1 once released. In-flight beats are discarded; no partial output appears after release.
- Pipeline has 3 register stages:
  - S1 registers calc_in, tw_in and the mode bits.
  - S2 registers the twiddle products.
  - S3 registers the butterfly outputs.
- Latency: a beat accepted at edge k gives out_valid=1 after edge k+3, provided there is no stall.
- Handshake:
  - en = out_ready | ~out_valid; in_ready = en.
  - A beat is transferred when in_valid & in_ready.
  - When en = 0, all stages hold (global stall).
  - Bubbles advance with en; stage valid bits shift with en.
  - Output data and ovf stay stable while out_valid & ~out_ready.
  - No beat is lost or duplicated; order is preserved.
- Twiddle multiply (S2), for B'=B*W1, C'=C*W2, D'=D*W3:
  - Inverse mode uses conj(W).
  - Bypass passes the input unchanged.
  - Each component uses a full-precision product sum (DW+TW+1 bits), adds 2^(TW-3), then arithmetic-shifts right by TW-2 (round half up). The result is saturated to DW bits; saturation here also sets ovf for that beat.
  - Three-multiplier or four-multiplier form is allowed; results must be bit-identical to the direct form.
- Butterfly (S3), computed at DW+2 bits:
  - X0 = A+B'+C'+D'
  - X1 = A-jB'-C'+jD'
  - X2 = A-B'+C'-D'
  - X3 = A+jB'-C'-jD'
  - Inverse mode swaps the sign of every j term.
  - Multiplying by -j maps (r,i) to (i,-r).
- Scaling: add 2^(scale-1) when scale > 0, then arithmetic-shift right by scale.
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1]; ovf = OR of all 8 component clamps plus the S2 clamps.
- Mode bits and scale travel with the beat; they may change every beat.

Test Plan:
- Latency and sums, with DW=17, TW=9, bypass=1, scale=0: A=B=C=D=(100,0), single beat. Expect X0=(400,0) and X1=X2=X3=(0,0), with out_valid exactly 3 cycles after the accept and ovf=0.
- j terms, with bypass=1: B=(100,0), A=C=D=0.
  - Forward: X0=(100,0), X1=(0,-100), X2=(-100,0), X3=(0,100).
  - Repeat with inverse=1: X1=(0,100), X3=(0,-100).
- Twiddle rounding, with bypass=0: W1=(0,-128), W2=W3=(128,0), B=(100,0), others 0. Expect B'=(0,-100) (from -12800+64 >>> 7), X0=(0,-100), X1=(-100,0); all outputs ±100 only.
- Saturation and scaling, with bypass=1: all inputs (65535,0).
  - scale=0: X0.Re=65535 (clamped from 262140) with ovf=1.
  - scale=2: X0.Re=65535 with ovf=0; the other outputs are 0.
- Backpressure: 10 back-to-back beats carrying distinct A values (bypass, others 0), with out_ready=0 for cycles 4-8. Expect in_ready low while stalled, outputs held stable, and all 10 outputs in order with X0=A.
- Reset mid-flight: assert reset with 3 beats in the pipe. Expect outputs immediately 0 and out_valid=0. After release, a new beat produces a correct result after 3 cycles, and no stale beat appears.
